// File: rtl/game_pkg.sv
// Shared game constants and the object-slot record used by the bullet engine
// and by later enemy/collision blocks.
package game_pkg;
  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int SHIP_W          = 16;
  localparam int BULLET_W        = 2;
  localparam int BULLET_H        = 6;
  localparam int SPEED           = 4;
  localparam int COOLDOWN_FRAMES = 8;

  localparam int X_W = $clog2(SCREEN_W);
  localparam int Y_W = $clog2(SCREEN_H);

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } slot_t;
endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: holds position/liveness, applies spawn/move strobes and
// reports whether the current scan pixel falls inside the bullet.
module bullet_slot #(
  parameter int BULLET_W = game_pkg::BULLET_W,
  parameter int BULLET_H = game_pkg::BULLET_H,
  parameter int SPEED    = game_pkg::SPEED
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       spawn,
  input  logic       move,
  input  logic [9:0] spawn_x,
  input  logic [8:0] spawn_y,
  input  logic [9:0] pixel_x,
  input  logic [8:0] pixel_y,
  output logic       active,
  output logic       active_nxt,
  output logic       hit
);
  import game_pkg::*;

  localparam logic [8:0] SPEED_Y = 9'(SPEED);

  slot_t       slot_q, slot_d;
  logic [10:0] x_end;
  logic [9:0]  y_end;

  always_comb begin
    slot_d = slot_q;
    if (spawn) begin
      slot_d.active = 1'b1;
      slot_d.x      = spawn_x;
      slot_d.y      = spawn_y;
    end else if (move && slot_q.active) begin
      // Retire instead of wrapping when the bullet would cross the top edge.
      if (slot_q.y < SPEED_Y) slot_d.active = 1'b0;
      else                    slot_d.y      = slot_q.y - SPEED_Y;
    end
  end

  always_comb begin
    x_end = {1'b0, slot_q.x} + 11'(BULLET_W);
    y_end = {1'b0, slot_q.y} + 10'(BULLET_H);
    hit   = slot_q.active
          && (pixel_x >= slot_q.x) && ({1'b0, pixel_x} < x_end)
          && (pixel_y >= slot_q.y) && ({1'b0, pixel_y} < y_end);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) slot_q <= '0;
    else         slot_q <= slot_d;
  end

  assign active     = slot_q.active;
  assign active_nxt = slot_d.active;
endmodule

// File: rtl/bullet_engine.sv
// Player bullet pool: fire synchroniser and edge detect, shot cooldown,
// lowest-free slot allocation, per-frame motion and per-pixel hit output.
module bullet_engine #(
  parameter int NUM_BULLETS     = 8,
  parameter int BULLET_W        = game_pkg::BULLET_W,
  parameter int BULLET_H        = game_pkg::BULLET_H,
  parameter int SHIP_W          = game_pkg::SHIP_W,
  parameter int SPEED           = game_pkg::SPEED,
  parameter int COOLDOWN_FRAMES = game_pkg::COOLDOWN_FRAMES
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       fire,
  input  logic       pause,
  input  logic       frame_tick,
  input  logic [9:0] ship_x,
  input  logic [8:0] ship_y,
  input  logic [9:0] pixel_x,
  input  logic [8:0] pixel_y,
  output logic       is_bullet,
  output logic [4:0] active_count,
  output logic       fire_dropped
);
  import game_pkg::*;

  localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN_FRAMES);
  localparam logic [9:0] X_OFFSET = 10'(SHIP_W / 2 - BULLET_W / 2);

  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0] cooldown_q, cooldown_d;
  logic is_bullet_q, is_bullet_d;
  logic [4:0] active_count_q, active_count_d;
  logic fire_dropped_q, fire_dropped_d;

  logic [NUM_BULLETS-1:0] slot_active, slot_active_nxt, slot_hit;
  logic [NUM_BULLETS-1:0] first_free, spawn_vec;
  logic press, valid, found, accept, move;
  logic [X_W-1:0] spawn_x;
  logic [Y_W-1:0] spawn_y;

  always_comb begin
    sync1_d = fire;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press   = sync2_q & ~prev_q;
    valid   = press && !pause && (cooldown_q == 8'd0) && (ship_y >= 9'(BULLET_H));
    move    = frame_tick & ~pause;

    // Free slots are judged from registered state, so a slot retiring on this
    // same edge is never handed out until the following cycle.
    found      = 1'b0;
    first_free = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!slot_active[i] && !found) begin
        first_free[i] = 1'b1;
        found         = 1'b1;
      end
    end
    accept         = valid & found;
    spawn_vec      = accept ? first_free : '0;
    fire_dropped_d = valid & ~found;

    spawn_x = ship_x + X_OFFSET;
    spawn_y = ship_y - 9'(BULLET_H);

    cooldown_d = cooldown_q;
    if (accept)                            cooldown_d = CD_LOAD;
    else if (move && cooldown_q != 8'd0)   cooldown_d = cooldown_q - 8'd1;

    is_bullet_d    = |slot_hit;
    active_count_d = '0;
    for (int i = 0; i < NUM_BULLETS; i++)
      active_count_d = active_count_d + 5'(slot_active_nxt[i]);
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H),
      .SPEED    (SPEED)
    ) u_slot (
      .iVGA_CLK   (iVGA_CLK),
      .iRST_n     (iRST_n),
      .spawn      (spawn_vec[g]),
      .move       (move),
      .spawn_x    (spawn_x),
      .spawn_y    (spawn_y),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .active     (slot_active[g]),
      .active_nxt (slot_active_nxt[g]),
      .hit        (slot_hit[g])
    );
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      cooldown_q     <= '0;
      is_bullet_q    <= 1'b0;
      active_count_q <= '0;
      fire_dropped_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      cooldown_q     <= cooldown_d;
      is_bullet_q    <= is_bullet_d;
      active_count_q <= active_count_d;
      fire_dropped_q <= fire_dropped_d;
    end
  end

  assign is_bullet    = is_bullet_q;
  assign active_count = active_count_q;
  assign fire_dropped = fire_dropped_q;
endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with a behavioural pool model compared
// every cycle, plus literal expectations for the key scenarios.
module tb_bullet_engine;
  localparam int NB = 8;
  localparam int BW = 2;
  localparam int BH = 6;
  localparam int SP = 4;
  localparam int CD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fire = 1'b0, pause = 1'b0, frame_tick = 1'b0;
  logic [9:0] ship_x = '0, pixel_x = '0;
  logic [8:0] ship_y = '0, pixel_y = '0;
  logic       is_bullet, fire_dropped;
  logic [4:0] active_count;

  always #20 clk = ~clk;

  bullet_engine dut (
    .iVGA_CLK     (clk),
    .iRST_n       (rst_n),
    .fire         (fire),
    .pause        (pause),
    .frame_tick   (frame_tick),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .is_bullet    (is_bullet),
    .active_count (active_count),
    .fire_dropped (fire_dropped)
  );

  int n_chk = 0, n_err = 0, drop_seen = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot arrays, cooldown and fire sample history.
  int m_act[NB], m_x[NB], m_y[NB];
  int m_cd;
  bit h1, h2, h3;
  int exp_hit, exp_cnt, exp_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_cd = 0; h1 = 0; h2 = 0; h3 = 0;
      exp_hit = 0; exp_cnt = 0; exp_drop = 0;
    end else begin : mdl
      int free;
      bit valid, tk;
      exp_hit = 0;
      for (int i = 0; i < NB; i++)
        if (m_act[i] != 0 && int'(pixel_x) >= m_x[i] && int'(pixel_x) < m_x[i] + BW &&
            int'(pixel_y) >= m_y[i] && int'(pixel_y) < m_y[i] + BH)
          exp_hit = 1;
      valid = h2 && !h3 && !pause && m_cd == 0 && int'(ship_y) >= BH;
      tk    = frame_tick && !pause;
      free  = -1;
      for (int i = 0; i < NB; i++)
        if (m_act[i] == 0 && free < 0) free = i;
      for (int i = 0; i < NB; i++)
        if (tk && m_act[i] != 0) begin
          if (m_y[i] < SP) m_act[i] = 0;
          else             m_y[i] = m_y[i] - SP;
        end
      exp_drop = (valid && free < 0) ? 1 : 0;
      if (valid && free >= 0) begin
        m_act[free] = 1;
        m_x[free]   = int'(ship_x) + 16 / 2 - BW / 2;
        m_y[free]   = int'(ship_y) - BH;
        m_cd        = CD;
      end else if (tk && m_cd > 0) begin
        m_cd = m_cd - 1;
      end
      exp_cnt = 0;
      for (int i = 0; i < NB; i++) exp_cnt += m_act[i];
      h3 = h2; h2 = h1; h1 = fire;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("is_bullet", int'(is_bullet), exp_hit);
      chk("active_count", int'(active_count), exp_cnt);
      chk("fire_dropped", int'(fire_dropped), exp_drop);
    end
  end

  always @(negedge clk) if (fire_dropped) drop_seen++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(1);
    end
  endtask

  task automatic press();
    fire = 1'b1; cyc(4);
    fire = 1'b0; cyc(4);
  endtask

  // The press is accepted on the third edge after fire rises; frame_tick is
  // made to land on exactly that edge.
  task automatic press_with_tick();
    fire = 1'b1; cyc(2);
    frame_tick = 1'b1; cyc(1);
    frame_tick = 1'b0; cyc(2);
    fire = 1'b0; cyc(4);
  endtask

  task automatic set_px(input int x, input int y);
    pixel_x = 10'(x); pixel_y = 9'(y); cyc(2);
  endtask

  initial begin
    cyc(3);
    chk_en = 1'b1;
    cyc(1);
    chk("reset is_bullet", int'(is_bullet), 0);
    chk("reset active_count", int'(active_count), 0);
    chk("reset fire_dropped", int'(fire_dropped), 0);
    rst_n = 1'b1; cyc(2);

    // Spawn position and render window
    ship_x = 10'd320; ship_y = 9'd450;
    pixel_x = 10'd327; pixel_y = 9'd444;
    press();
    chk("spawn count", int'(active_count), 1);
    chk("model x0", m_x[0], 327);
    chk("model y0", m_y[0], 444);
    chk("hit 327,444", int'(is_bullet), 1);
    set_px(329, 444); chk("miss 329,444", int'(is_bullet), 0);
    set_px(328, 449); chk("hit 328,449", int'(is_bullet), 1);
    set_px(328, 450); chk("miss 328,450", int'(is_bullet), 0);
    set_px(326, 444); chk("miss 326,444", int'(is_bullet), 0);

    // Motion up to the top row, then retirement
    set_px(327, 0);
    tick_n(111);
    chk("model y0 at top", m_y[0], 0);
    chk("alive at y=0", int'(active_count), 1);
    chk("hit at y=0", int'(is_bullet), 1);
    tick_n(1); cyc(1);
    chk("retired count", int'(active_count), 0);
    chk("retired hit", int'(is_bullet), 0);

    // Cooldown gating
    press();
    chk("cd first accept", int'(active_count), 1);
    tick_n(3);
    press();
    chk("cd press ignored", int'(active_count), 1);
    chk("cd no drop", drop_seen, 0);
    tick_n(5);
    press();
    chk("cd second accept", int'(active_count), 2);
    chk("model slot1 active", m_act[1], 1);

    // Fill the pool, then one press too many
    repeat (6) begin tick_n(8); press(); end
    chk("pool full", int'(active_count), 8);
    tick_n(8);
    press();
    chk("drop pulse once", drop_seen, 1);
    chk("full unchanged", int'(active_count), 8);

    // Same-cycle retire and spawn
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
    ship_y = 9'd450; press(); tick_n(8);
    press(); tick_n(8);
    ship_y = 9'd40; press(); tick_n(8);
    chk("model slot2 y", m_y[2], 2);
    ship_y = 9'd200;
    press_with_tick();
    chk("collide count", int'(active_count), 3);
    chk("model slot2 retired", m_act[2], 0);
    chk("model slot3 spawned", m_act[3], 1);
    chk("model slot3 unmoved", m_y[3], 194);
    set_px(327, 199); chk("new bullet bottom row", int'(is_bullet), 1);
    set_px(327, 200); chk("below new bullet", int'(is_bullet), 0);
    set_px(327, 199);

    // Pause freezes motion, spawns and cooldown
    pause = 1'b1;
    tick_n(5);
    press();
    chk("pause count", int'(active_count), 3);
    chk("pause render", int'(is_bullet), 1);
    pause = 1'b0;
    tick_n(3);
    press();
    chk("cooldown held in pause", int'(active_count), 3);

    // Ship too close to the top edge
    tick_n(8);
    ship_y = 9'd5;
    press();
    chk("low ship ignored", int'(active_count), 3);
    chk("low ship no drop", drop_seen, 1);

    // Asynchronous reset mid-cycle
    pixel_x = 10'd327; pixel_y = 9'd10;
    @(posedge clk); #5;
    rst_n = 1'b0;
    #2;
    chk("async rst count", int'(active_count), 0);
    chk("async rst is_bullet", int'(is_bullet), 0);
    chk("async rst drop", int'(fire_dropped), 0);
    cyc(2);
    rst_n = 1'b1; cyc(1);
    ship_y = 9'd450;
    press();
    chk("after reset spawn", int'(active_count), 1);
    chk("after reset slot0", m_act[0], 1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
